// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
//
// Samples one raw push-button pin, synchronises it into the clk domain,
// debounces it and decodes it into a clean pressed level plus single-cycle
// event pulses (press, release, short press, long press, optional repeat).
//
// Optional feature macro: BUTTON_AUTOREPEAT_EN
//   defined   : after a long press, repeat_pulse fires every REPEAT_MS while
//               the button stays held.
//   undefined : no repeat counter is built and repeat_pulse is tied to 0.
//
// Ports:
//   clk           in   system clock (12 MHz on the board)
//   rst           in   synchronous, active-high reset
//   btn_raw       in   asynchronous raw button pin
//   btn_level     out  debounced pressed state, 1 = pressed
//   press_pulse   out  one-cycle pulse on accepted press
//   release_pulse out  one-cycle pulse on accepted release
//   short_pulse   out  one-cycle pulse on release when no long press occurred
//   long_pulse    out  one-cycle pulse when the hold reaches LONG_MS
//   repeat_pulse  out  one-cycle auto-repeat pulse (0 unless feature enabled)
// ---------------------------------------------------------------------------
module button_event_decoder #(
   parameter int unsigned CLK_HZ      = 12_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned LONG_MS     = 1000,
   parameter int unsigned REPEAT_MS   = 200,
   parameter int unsigned ACTIVE_LOW  = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   // Cycle counts derived from the millisecond parameters.
   localparam int unsigned DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int unsigned LONG_CYC = CLK_HZ / 1000 * LONG_MS;
   localparam int unsigned REP_CYC  = CLK_HZ / 1000 * REPEAT_MS;

   localparam int unsigned DB_W   = $clog2(DB_CYC + 1);
   localparam int unsigned LONG_W = $clog2(LONG_CYC + 1);

   localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
   localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYC);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

   // Raw pin value that means "not pressed".
   localparam logic RAW_RELEASED = (ACTIVE_LOW != 0);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_DB_PRESS   = 2'd1;
   localparam logic [1:0] ST_PRESSED    = 2'd2;
   localparam logic [1:0] ST_DB_RELEASE = 2'd3;

   // Elaboration-time sanity checks on the derived constants.
   if (DB_CYC < 1) begin : g_db_check
      $error("button_event_decoder: debounce cycle count must be at least 1");
   end
   if (LONG_CYC < 1) begin : g_long_check
      $error("button_event_decoder: long-press cycle count must be at least 1");
   end
   if (REP_CYC < 1) begin : g_rep_check
      $error("button_event_decoder: repeat cycle count must be at least 1");
   end

   // ------------------------------------------------------------------------
   // Two-flop synchroniser. Reset loads the released level so that leaving
   // reset can never look like a press edge.
   // ------------------------------------------------------------------------
   logic sync1_q;
   logic sync2_q;
   logic btn_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= RAW_RELEASED;
         sync2_q <= RAW_RELEASED;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Polarity correction: 1 = pressed regardless of pin polarity.
   assign btn_sync = sync2_q ^ RAW_RELEASED;

   // ------------------------------------------------------------------------
   // Debounce / event FSM
   // ------------------------------------------------------------------------
   logic [1:0]        state_q, state_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [LONG_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              long_seen_q, long_seen_d;
   logic              level_q, level_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              short_q, short_d;
   logic              long_q, long_d;

   always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      long_seen_d = long_seen_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      short_d     = 1'b0;
      long_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (btn_sync) begin
               if (DB_CYC == 1) begin
                  // A single stable sample is enough: accept immediately.
                  state_d     = ST_PRESSED;
                  hold_cnt_d  = '0;
                  long_seen_d = 1'b0;
                  level_d     = 1'b1;
                  press_d     = 1'b1;
               end else begin
                  state_d  = ST_DB_PRESS;
                  db_cnt_d = DB_ONE;
               end
            end
         end

         ST_DB_PRESS: begin
            if (!btn_sync) begin
               state_d = ST_IDLE;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = ST_PRESSED;
               hold_cnt_d  = '0;
               long_seen_d = 1'b0;
               level_d     = 1'b1;
               press_d     = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         ST_PRESSED: begin
            // Hold time runs in every PRESSED cycle, including the one where
            // the pin first reads released; it freezes only in DB_RELEASE.
            if (hold_cnt_q != LONG_MAX) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
               if (hold_cnt_q == LONG_LAST && !long_seen_q) begin
                  long_d      = 1'b1;
                  long_seen_d = 1'b1;
               end
            end
            if (!btn_sync) begin
               if (DB_CYC == 1) begin
                  state_d   = ST_IDLE;
                  level_d   = 1'b0;
                  release_d = 1'b1;
                  short_d   = !long_seen_d;
               end else begin
                  state_d  = ST_DB_RELEASE;
                  db_cnt_d = DB_ONE;
               end
            end
         end

         ST_DB_RELEASE: begin
            if (btn_sync) begin
               // Bounce: resume the hold with its time and long flag intact.
               state_d = ST_PRESSED;
            end else if (db_cnt_q == DB_LAST) begin
               state_d   = ST_IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
               short_d   = !long_seen_q;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         db_cnt_q    <= '0;
         hold_cnt_q  <= '0;
         long_seen_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         short_q     <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         long_seen_q <= long_seen_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         short_q     <= short_d;
         long_q      <= long_d;
      end
   end

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_pulse   = short_q;
   assign long_pulse    = long_q;

   // ------------------------------------------------------------------------
   // Auto-repeat
   // ------------------------------------------------------------------------
`ifdef BUTTON_AUTOREPEAT_EN
   localparam int unsigned       REP_W    = $clog2(REP_CYC + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CYC - 1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             repeat_q, repeat_d;

   // long_seen_q is first high in the long_pulse cycle, so counting from
   // there puts the first repeat REP_CYC cycles after it and never on it.
   always_comb begin
      rep_cnt_d = rep_cnt_q;
      repeat_d  = 1'b0;
      case (state_q)
         ST_PRESSED: begin
            if (long_seen_q) begin
               if (rep_cnt_q == REP_LAST) begin
                  rep_cnt_d = '0;
                  repeat_d  = 1'b1;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
            end
         end
         ST_DB_RELEASE: begin
            rep_cnt_d = rep_cnt_q;
         end
         default: begin
            rep_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt_q <= '0;
         repeat_q  <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         repeat_q  <= repeat_d;
      end
   end

   assign repeat_pulse = repeat_q;
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_button_event_decoder
//
// Drives button_event_decoder (CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20,
// REPEAT_MS=5, active-low pin) with directed scenarios followed by random
// press/release/reset segments. A behavioural model predicts every output
// each cycle from run lengths of the synchronised button value; directed
// scenarios additionally check event counts and relative event timing.
// ---------------------------------------------------------------------------
module tb_button_event_decoder;

   localparam int DB   = 4;
   localparam int LONG = 20;
   localparam int REP  = 5;
`ifdef BUTTON_AUTOREPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_raw = 1'b1;
   logic btn_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;

   button_event_decoder #(
      .CLK_HZ      (1000),
      .DEBOUNCE_MS (4),
      .LONG_MS     (20),
      .REPEAT_MS   (5),
      .ACTIVE_LOW  (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_raw       (btn_raw),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .short_pulse   (short_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // Model state: a 2-sample delay line of "pressed", the previous synced
   // sample, the debounced level, the length of the current run that
   // disagrees with the level, and the number of counted hold cycles.
   bit m_d1 = 1'b0, m_d2 = 1'b0, m_prev = 1'b0, m_level = 1'b0;
   int m_run = 0, m_count = 0;
   bit e_level = 1'b0, e_press = 1'b0, e_rel = 1'b0, e_short = 1'b0;
   bit e_long = 1'b0, e_rep = 1'b0;

   // Observed event bookkeeping for directed scenarios.
   int n_press, n_rel, n_short, n_long, n_rep;
   int t_press, t_rel, t_long, t_rep_first;

   task automatic check(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // Advance the model across one clock edge given the inputs held before it.
   task automatic model_step(input bit r, input bit raw);
      bit s;
      s       = m_d2;
      e_press = 1'b0;
      e_rel   = 1'b0;
      e_short = 1'b0;
      e_long  = 1'b0;
      e_rep   = 1'b0;
      if (r) begin
         m_d1 = 1'b0; m_d2 = 1'b0; m_prev = 1'b0; m_level = 1'b0;
         m_run = 0; m_count = 0; e_level = 1'b0;
         return;
      end
      // A held cycle counts toward hold time unless a release is being
      // debounced, i.e. unless the previous synced sample read released.
      if (m_level && m_prev) begin
         m_count++;
         if (m_count == LONG) e_long = 1'b1;
         if (REP_ON && m_count > LONG && (m_count - LONG) % REP == 0) e_rep = 1'b1;
      end
      if (s != m_level) m_run++;
      else m_run = 0;
      if (m_run == DB) begin
         m_run   = 0;
         m_level = !m_level;
         if (m_level) begin
            e_press = 1'b1;
            m_count = 0;
         end else begin
            e_rel   = 1'b1;
            e_short = (m_count < LONG);
         end
      end
      e_level = m_level;
      m_prev  = s;
      m_d2    = m_d1;
      m_d1    = !raw;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(rst, btn_raw);
      cyc++;
      #1;
      check("btn_level", btn_level, e_level);
      check("press_pulse", press_pulse, e_press);
      check("release_pulse", release_pulse, e_rel);
      check("short_pulse", short_pulse, e_short);
      check("long_pulse", long_pulse, e_long);
      check("repeat_pulse", repeat_pulse, e_rep);
      if (press_pulse === 1'b1) begin n_press++; t_press = cyc; end
      if (release_pulse === 1'b1) begin n_rel++; t_rel = cyc; end
      if (short_pulse === 1'b1) n_short++;
      if (long_pulse === 1'b1) begin n_long++; t_long = cyc; end
      if (repeat_pulse === 1'b1) begin
         if (n_rep == 0) t_rep_first = cyc;
         n_rep++;
      end
   endtask

   task automatic hold(input int n, input bit pressed);
      btn_raw = !pressed;
      repeat (n) tick();
   endtask

   task automatic clear_events();
      n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_rep = 0;
      t_press = -1000; t_rel = -1000; t_long = -1000; t_rep_first = -1000;
   endtask

   initial begin
      int t_rst;
      clear_events();

      // Reset state.
      rst = 1'b1;
      btn_raw = 1'b1;
      repeat (3) tick();
      check("reset_level", btn_level, 1'b0);
      rst = 1'b0;
      hold(5, 1'b0);

      // Glitch shorter than the debounce window.
      clear_events();
      hold(3, 1'b1);
      hold(20, 1'b0);
      check_int("glitch_press_count", n_press, 0);
      check_int("glitch_release_count", n_rel, 0);

      // Short press.
      clear_events();
      hold(12, 1'b1);
      hold(20, 1'b0);
      check_int("short_press_count", n_press, 1);
      check_int("short_release_count", n_rel, 1);
      check_int("short_short_count", n_short, 1);
      check_int("short_long_count", n_long, 0);
      check_int("short_release_minus_press", t_rel - t_press, 12);

      // Long press.
      clear_events();
      hold(30, 1'b1);
      hold(20, 1'b0);
      check_int("long_long_count", n_long, 1);
      check_int("long_short_count", n_short, 0);
      check_int("long_release_count", n_rel, 1);
      check_int("long_delay", t_long - t_press, LONG);

      // Release bounce while held.
      clear_events();
      hold(10, 1'b1);
      hold(2, 1'b0);
      hold(30, 1'b1);
      hold(20, 1'b0);
      check_int("bounce_press_count", n_press, 1);
      check_int("bounce_release_count", n_rel, 1);
      check_int("bounce_long_delay", t_long - t_press, LONG + 2);

      // Reset mid-hold at P+5, button still held.
      clear_events();
      hold(11, 1'b1);
      rst = 1'b1;
      tick();
      t_rst = cyc;
      check("midhold_reset_level", btn_level, 1'b0);
      check("midhold_reset_release", release_pulse, 1'b0);
      rst = 1'b0;
      hold(20, 1'b1);
      check_int("midhold_release_count", n_rel, 0);
      check_int("midhold_press_count", n_press, 2);
      check_int("midhold_repress_delay", t_press - t_rst, 2 + DB);
      hold(20, 1'b0);

      // 40-cycle hold: auto-repeat pulses, or none when the feature is off.
      clear_events();
      hold(40, 1'b1);
      hold(20, 1'b0);
      check_int("hold40_long_count", n_long, 1);
      if (REP_ON) begin
         check_int("hold40_repeat_count", n_rep, 3);
         check_int("hold40_first_repeat", t_rep_first - t_press, LONG + REP);
      end else begin
         check_int("hold40_repeat_count", n_rep, 0);
      end

      // Random segments with occasional resets.
      for (int seg = 0; seg < 80; seg++) begin
         int len;
         bit lvl;
         len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6))
                                           : int'($urandom_range(7, 45));
         lvl = bit'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         hold(len, lvl);
      end
      hold(40, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
